mdu_sequencer: RTL and testbench

- Sequences the E-stage multiply/divide resource. Latches operands and MDUOp on a start pulse, then holds busy for a fixed latency. Commits the result to architectural HI/LO when that latency expires.
- Sits beside the E-stage ALU. Feeds the hazard controller a stall request for MDU-related D-stage instructions, and feeds the E-stage AO mux with HI/LO.
- The E-stage exception path gates new operations that are being flushed.

---
 rtl/mdu_sequencer_pkg.sv | 24 ++
 rtl/mdu_sequencer_if.sv | 28 ++
 rtl/mdu_arith.sv | 66 ++++++
 rtl/mdu_sequencer.sv | 111 +++++++++++
 tb/tb_mdu_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU constants: operation encodings, default latencies and FSM states.
package mdu_sequencer_pkg;

  localparam int unsigned MDU_WIDTH       = 32;
  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;
  localparam int unsigned MDU_CNT_W       = 4;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_sequencer_if.sv
// E-stage MDU request/response bundle between the pipeline and the sequencer.
interface mdu_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();
  import mdu_sequencer_pkg::*;

  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             d_mdu_related;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, d_mdu_related,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, d_mdu_related,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational {hi,lo} result for mult/multu/div/divu; wr=0 for a zero divisor.
module mdu_arith
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             wr
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   abs_a, abs_b, safe_b, mag_b;
  logic [WIDTH-1:0]   q_u, r_u, q_mag, r_mag;
  logic               neg_a, neg_b;

  // Low 2W bits of a sign-extended unsigned multiply equal the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign neg_a = a[WIDTH-1];
  assign neg_b = b[WIDTH-1];
  assign abs_a = neg_a ? (~a + WIDTH'(1)) : a;
  assign abs_b = neg_b ? (~b + WIDTH'(1)) : b;

  // Divisor forced non-zero so the divider never sees 0; the result is discarded then.
  assign safe_b = (b == '0) ? WIDTH'(1) : b;
  assign mag_b  = (abs_b == '0) ? WIDTH'(1) : abs_b;
  assign q_u    = a / safe_b;
  assign r_u    = a % safe_b;
  assign q_mag  = abs_a / mag_b;
  assign r_mag  = abs_a % mag_b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    wr     = 1'b0;
    case (op)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        wr = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        wr = 1'b1;
      end
      OP_DIV: begin
        // MIN / -1 falls out naturally: magnitude 2^(W-1), signs equal, no negate.
        res_lo = (neg_a ^ neg_b) ? (~q_mag + WIDTH'(1)) : q_mag;
        res_hi = neg_a ? (~r_mag + WIDTH'(1)) : r_mag;
        wr     = (b != '0);
      end
      OP_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
        wr     = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer: fixed-latency busy window, HI/LO commit, stall request.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = MDU_WIDTH,
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int unsigned CNT_W       = MDU_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  mdu_sequencer_if.slave  bus
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;
  logic             accept;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .wr     (res_wr)
  );

  assign accept        = bus.start & ~bus.cancel & (state_q == ST_IDLE);
  assign bus.stall_req = bus.d_mdu_related & (busy_q | bus.start);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = ST_BUSY;
              busy_d    = 1'b1;
              count_d   = (bus.op == OP_MULT || bus.op == OP_MULTU) ?
                          CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              pend_we_d = res_wr;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against an arithmetic reference model.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] m_hi, m_lo;

  mdu_sequencer_if #(.WIDTH(32)) bus ();

  mdu_sequencer #(
    .WIDTH(32), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard controller never issues start while an operation is in flight.
  always @(posedge clk) begin
    if (reset) assert (!(bus.start && bus.busy)) else $error("start issued while busy");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural result of one arithmetic op; wr=0 means HI/LO are left alone.
  function automatic void ref_arith(input mdu_op_e o, input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    int sa, sb;
    longint p;
    logic [63:0] u;
    sa = av;
    sb = bv;
    rh = '0;
    rl = '0;
    wr = 1'b1;
    case (o)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        {rh, rl} = p;
      end
      OP_MULTU: begin
        u = {32'b0, av} * {32'b0, bv};
        {rh, rl} = u;
      end
      OP_DIV: begin
        if (bv == 0) wr = 1'b0;
        else if (sa == 32'sh8000_0000 && sb == -1) begin
          rl = av;
          rh = '0;
        end else begin
          rl = sa / sb;
          rh = sa % sb;
        end
      end
      OP_DIVU: begin
        if (bv == 0) wr = 1'b0;
        else begin
          rl = av / bv;
          rh = av % bv;
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // Issue one start, then follow the whole busy window and commit.
  task automatic do_op(input mdu_op_e o, input logic [31:0] av, input logic [31:0] bv,
                       input logic can, input logic drel, input logic can_busy);
    logic [31:0] rh, rl;
    bit wr, arith;
    int n;
    @(negedge clk);
    check("done_idle", bus.done, 1'b0);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = av;
    bus.b = bv;
    bus.cancel = can;
    bus.d_mdu_related = drel;
    #1 check("stall_start", bus.stall_req, drel);
    arith = (o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU) && !can;
    n = (o == OP_MULT || o == OP_MULTU) ? MULT_N : DIV_N;
    ref_arith(o, av, bv, rh, rl, wr);
    if (!can && o == OP_MTHI) m_hi = av;
    if (!can && o == OP_MTLO) m_lo = av;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = OP_NONE;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.cancel = can_busy;
    if (arith) begin
      for (int i = 0; i < n; i++) begin
        #1;
        check("busy_hi", bus.busy, 1'b1);
        check("done_lo", bus.done, 1'b0);
        check("stall_busy", bus.stall_req, drel);
        check("hold_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        @(negedge clk);
      end
      if (wr) begin
        m_hi = rh;
        m_lo = rl;
      end
      #1;
      check("busy_end", bus.busy, 1'b0);
      check("done_pulse", bus.done, 1'b1);
      check("stall_end", bus.stall_req, 1'b0);
    end else begin
      #1;
      check("busy_none", bus.busy, 1'b0);
      check("done_none", bus.done, 1'b0);
    end
    check("hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    bus.cancel = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corner [4];
    corner[0] = 32'h0;
    corner[1] = 32'h8000_0000;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h1;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 100));
  endfunction

  initial begin
    mdu_op_e ops [7];
    n_checks = 0;
    n_errors = 0;
    m_hi = '0;
    m_lo = '0;
    ops[0] = OP_NONE; ops[1] = OP_MULT; ops[2] = OP_MULTU; ops[3] = OP_DIV;
    ops[4] = OP_DIVU; ops[5] = OP_MTHI; ops[6] = OP_MTLO;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.op = OP_NONE;
    bus.a = '0;
    bus.b = '0;
    bus.cancel = 1'b0;
    bus.d_mdu_related = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    reset = 1'b1;

    do_op(OP_MULT, 32'd3, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    check("plan_mult", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF4);
    do_op(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
    check("plan_divu", {bus.hi, bus.lo}, {32'd1, 32'd3});
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0);
    check("plan_div", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("plan_div_ovf", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
    do_op(OP_MTHI, 32'h11, 32'h0, 1'b0, 1'b1, 1'b0);
    do_op(OP_MTLO, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0);
    do_op(OP_DIV, 32'd100, 32'd0, 1'b0, 1'b1, 1'b0);
    check("plan_div0", {bus.hi, bus.lo}, {32'h11, 32'h22});
    do_op(OP_MULT, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    check("plan_cancel", {bus.hi, bus.lo}, {32'h11, 32'h22});
    do_op(OP_MTHI, 32'h99, 32'h0, 1'b1, 1'b0, 1'b0);
    do_op(OP_NONE, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0);
    do_op(OP_MULT, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
    check("plan_cancel_busy", {bus.hi, bus.lo}, {32'h0, 32'd25});

    // Asynchronous reset on the third busy cycle of a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.a = 32'h1234;
    bus.b = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = OP_NONE;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'h0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_busy", bus.busy, 1'b0);
      check("post_rst_done", bus.done, 1'b0);
      check("post_rst_hilo", {bus.hi, bus.lo}, 64'h0);
    end

    for (int k = 0; k < 60; k++) begin
      do_op(ops[$urandom_range(0, 6)], pick_operand(), pick_operand(),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
